// File: rtl/uart_tx_port_if.sv
// Processor-side register bus for uart_tx_port.
//   ce       : chip enable from the data-bus address decode
//   rw       : 1 = write (store), 0 = read (load)
//   address  : register select
//   data_in  : write data from the processor
//   data_out : read data back to the processor (combinational)
interface uart_tx_port_if;
  logic        ce;
  logic        rw;
  logic [1:0]  address;
  logic [7:0]  data_in;
  logic [15:0] data_out;

  modport master (output ce, rw, address, data_in, input  data_out);
  modport slave  (input  ce, rw, address, data_in, output data_out);
endinterface

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: 8N1 framing, LSB first, with a small
// byte FIFO in front of the serializer.
//   clk : system clock, all state changes on the rising edge
//   rst : asynchronous active-high reset
//   bus : register bus (slave side)
//         TX_DATA_ADDR   write -> queue byte (dropped + overflow if full)
//         TX_STATUS_ADDR write -> clear overflow
//         TX_STATUS_ADDR read  -> {12'b0, overflow, empty, full, busy}
//   tx  : serial output, idle high, registered
module uart_tx_port #(
  parameter int         DIVISOR        = 217,
  parameter int         FIFO_DEPTH     = 4,
  parameter logic [1:0] TX_DATA_ADDR   = 2'b00,
  parameter logic [1:0] TX_STATUS_ADDR = 2'b01
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_port_if.slave  bus,
  output logic           tx
);

  localparam int BW = $clog2(DIVISOR);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIVISOR - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            overflow;

  logic empty, full, busy, baud_wrap;
  logic wr_data, wr_status, rd_status;
  logic push, pop;

  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign busy      = (state != IDLE);
  assign baud_wrap = (baud_cnt == BAUD_LAST);

  assign wr_data   = bus.ce &  bus.rw & (bus.address == TX_DATA_ADDR);
  assign wr_status = bus.ce &  bus.rw & (bus.address == TX_STATUS_ADDR);
  assign rd_status = bus.ce & ~bus.rw & (bus.address == TX_STATUS_ADDR);

  // Full is judged on the pre-edge count, so a same-cycle pop cannot make
  // room for a write that arrived while full.
  assign push = wr_data & ~full;

  assign bus.data_out = rd_status ? {12'b0, overflow, empty, full, busy} : 16'h0000;

  // Next state; pop marks the edge that loads a new byte and starts a frame.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      IDLE:  if (!empty) begin
               state_n = START;
               pop     = 1'b1;
             end
      START: if (baud_wrap) state_n = DATA;
      DATA:  if (baud_wrap && bit_cnt == 3'd7) state_n = STOP;
      STOP:  if (baud_wrap) begin
               if (!empty) begin
                 state_n = START;
                 pop     = 1'b1;
               end else begin
                 state_n = IDLE;
               end
             end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // FIFO storage needs no reset: empty/full come from count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (wr_data && full) overflow <= 1'b1;
      else if (wr_status)  overflow <= 1'b0;
    end
  end

  // Serializer. tx always holds the level of the bit period now running;
  // at each baud wrap it is loaded with the level for the next period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (pop) begin
      shreg    <= mem[rd_ptr];
      baud_cnt <= '0;
      bit_cnt  <= '0;
      tx       <= 1'b0;
    end else if (state != IDLE) begin
      baud_cnt <= baud_wrap ? '0 : baud_cnt + BW'(1);
      if (baud_wrap) begin
        case (state)
          START: tx <= shreg[0];
          DATA:  if (bit_cnt == 3'd7) begin
                   tx <= 1'b1;
                 end else begin
                   shreg   <= shreg >> 1;
                   tx      <= shreg[1];
                   bit_cnt <= bit_cnt + 3'd1;
                 end
          STOP:  tx <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port with DIVISOR=4, FIFO_DEPTH=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_port;
  localparam int DIV = 4;
  localparam logic [1:0] A_DATA = 2'b00;
  localparam logic [1:0] A_STAT = 2'b01;

  logic clk, rst, tx;
  int   nvec, nfail;

  uart_tx_port_if ubus ();

  uart_tx_port #(
    .DIVISOR(DIV), .FIFO_DEPTH(4), .TX_DATA_ADDR(A_DATA), .TX_STATUS_ADDR(A_STAT)
  ) dut (
    .clk(clk), .rst(rst), .bus(ubus), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level k cycles after the falling edge of the start bit.
  function automatic logic exp_tx(input logic [7:0] b, input int k);
    int idx;
    idx = k / DIV;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  // One-edge write cycle; called and returns on a falling edge.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    ubus.ce = 1'b1; ubus.rw = 1'b1; ubus.address = a; ubus.data_in = d;
    @(negedge clk);
    ubus.ce = 1'b0; ubus.rw = 1'b0; ubus.data_in = 8'h00;
  endtask

  // Combinational read, no clock edge consumed.
  task automatic bus_read(input logic [1:0] a, output logic [15:0] v);
    ubus.ce = 1'b1; ubus.rw = 1'b0; ubus.address = a;
    #1 v = ubus.data_out;
    ubus.ce = 1'b0;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    rst = 1'b1;
    ubus.ce = 1'b0; ubus.rw = 1'b0; ubus.address = 2'b00; ubus.data_in = 8'h00;
    @(negedge clk); @(negedge clk);
    nvec++; if (tx !== 1'b1) begin nfail++; $display("FAIL reset_tx: got %b want 1", tx); end
    bus_read(A_STAT, v);
    nvec++; if (v !== 16'h0004) begin nfail++; $display("FAIL reset_status: got %h want 0004", v); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    nvec++; if (tx !== 1'b1) begin nfail++; $display("FAIL post_reset_tx: got %b want 1", tx); end
    bus_read(A_STAT, v);
    nvec++; if (v !== 16'h0004) begin nfail++; $display("FAIL post_reset_status: got %h want 0004", v); end
    ubus.address = A_STAT; #1;
    nvec++; if (ubus.data_out !== 16'h0000) begin nfail++; $display("FAIL ce_low_read: got %h want 0000", ubus.data_out); end
  endtask

  task automatic test_unused_addr;
    logic [15:0] v;
    @(negedge clk);
    bus_write(2'b10, 8'hFF);
    bus_write(2'b11, 8'h3C);
    @(negedge clk);
    nvec++; if (tx !== 1'b1) begin nfail++; $display("FAIL unused_wr_tx: got %b want 1", tx); end
    bus_read(A_STAT, v);
    nvec++; if (v !== 16'h0004) begin nfail++; $display("FAIL unused_wr_status: got %h want 0004", v); end
    bus_read(2'b10, v);
    nvec++; if (v !== 16'h0000) begin nfail++; $display("FAIL unused_rd: got %h want 0000", v); end
    bus_read(A_DATA, v);
    nvec++; if (v !== 16'h0000) begin nfail++; $display("FAIL data_addr_rd: got %h want 0000", v); end
  endtask

  task automatic test_single_frame;
    logic [15:0] v;
    @(negedge clk);
    bus_write(A_DATA, 8'hA5);
    nvec++; if (tx !== 1'b1) begin nfail++; $display("FAIL a5_pre_start: got %b want 1", tx); end
    @(negedge clk);
    for (int k = 0; k < 10*DIV; k++) begin
      nvec++;
      if (tx !== exp_tx(8'hA5, k)) begin
        nfail++; $display("FAIL a5_frame cyc%0d: got %b want %b", k, tx, exp_tx(8'hA5, k));
      end
      if (k == DIV) begin
        bus_read(A_STAT, v);
        nvec++; if (v !== 16'h0005) begin nfail++; $display("FAIL a5_busy_status: got %h want 0005", v); end
      end
      @(negedge clk);
    end
    bus_read(A_STAT, v);
    nvec++; if (v !== 16'h0004) begin nfail++; $display("FAIL a5_done_status: got %h want 0004", v); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] v;
    logic [7:0]  b;
    bus_write(A_DATA, 8'h55);
    bus_write(A_DATA, 8'hAA);
    for (int k = 0; k < 20*DIV; k++) begin
      b = (k < 10*DIV) ? 8'h55 : 8'hAA;
      nvec++;
      if (tx !== exp_tx(b, k % (10*DIV))) begin
        nfail++; $display("FAIL b2b_frame cyc%0d: got %b want %b", k, tx, exp_tx(b, k % (10*DIV)));
      end
      @(negedge clk);
    end
    bus_read(A_STAT, v);
    nvec++; if (v !== 16'h0004) begin nfail++; $display("FAIL b2b_done_status: got %h want 0004", v); end
  endtask

  task automatic test_overflow;
    logic [15:0] v;
    logic [7:0]  b;
    @(negedge clk);
    bus_write(A_DATA, 8'h01);   // frame starts on the next edge
    bus_write(A_DATA, 8'h02);
    bus_write(A_DATA, 8'h03);
    bus_write(A_DATA, 8'h04);
    bus_read(A_STAT, v);
    nvec++; if (v !== 16'h0001) begin nfail++; $display("FAIL ovf_3queued: got %h want 0001", v); end
    bus_write(A_DATA, 8'h05);
    bus_read(A_STAT, v);
    nvec++; if (v !== 16'h0003) begin nfail++; $display("FAIL ovf_full: got %h want 0003", v); end
    bus_write(A_DATA, 8'h06);   // dropped
    bus_read(A_STAT, v);
    nvec++; if (v !== 16'h000B) begin nfail++; $display("FAIL ovf_set: got %h want 000b", v); end
    bus_write(A_STAT, 8'hFF);
    bus_read(A_STAT, v);
    nvec++; if (v !== 16'h0003) begin nfail++; $display("FAIL ovf_clear: got %h want 0003", v); end
    // Frame 0x01 began five cycles ago; the rest must follow unchanged.
    for (int k = 5; k < 50*DIV; k++) begin
      b = 8'h01 + 8'(k / (10*DIV));
      nvec++;
      if (tx !== exp_tx(b, k % (10*DIV))) begin
        nfail++; $display("FAIL ovf_drain cyc%0d byte%h: got %b want %b", k, b, tx, exp_tx(b, k % (10*DIV)));
      end
      @(negedge clk);
    end
    bus_read(A_STAT, v);
    nvec++; if (v !== 16'h0004) begin nfail++; $display("FAIL ovf_drained: got %h want 0004", v); end
  endtask

  task automatic test_reset_mid_frame;
    logic [15:0] v;
    bus_write(A_DATA, 8'hA5);
    bus_write(A_DATA, 8'h3C);
    repeat (10) @(negedge clk);
    nvec++; if (tx !== 1'b0) begin nfail++; $display("FAIL midrst_pre: got %b want 0", tx); end
    #1 rst = 1'b1;
    #1;
    nvec++; if (tx !== 1'b1) begin nfail++; $display("FAIL midrst_async_tx: got %b want 1", tx); end
    @(negedge clk);
    rst = 1'b0;
    bus_read(A_STAT, v);
    nvec++; if (v !== 16'h0004) begin nfail++; $display("FAIL midrst_status: got %h want 0004", v); end
    repeat (3) begin
      @(negedge clk);
      nvec++; if (tx !== 1'b1) begin nfail++; $display("FAIL midrst_discard: got %b want 1", tx); end
    end
    bus_write(A_DATA, 8'h5A);
    @(negedge clk);
    for (int k = 0; k < 10*DIV; k++) begin
      nvec++;
      if (tx !== exp_tx(8'h5A, k)) begin
        nfail++; $display("FAIL postrst_frame cyc%0d: got %b want %b", k, tx, exp_tx(8'h5A, k));
      end
      @(negedge clk);
    end
    bus_read(A_STAT, v);
    nvec++; if (v !== 16'h0004) begin nfail++; $display("FAIL postrst_done: got %h want 0004", v); end
  endtask

  initial begin
    nvec = 0; nfail = 0;
    test_reset;
    test_unused_addr;
    test_single_frame;
    test_back_to_back;
    test_overflow;
    test_reset_mid_frame;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
